// File: rtl/acc_wr_arb_if.sv
// Request/write-port bundle for acc_wr_arb: two request lanes in, one accumulator write port out.
interface acc_wr_arb_if;
    logic [4:0]  wen_vctr0_i_awa;
    logic [31:0] wdata0_i_awa;
    logic        rdy0_o_awa;
    logic [4:0]  wen_vctr1_i_awa;
    logic [31:0] wdata1_i_awa;
    logic        rdy1_o_awa;
    logic [4:0]  acc_wen_vctr_o_awa;
    logic [31:0] acc_wdata_o_awa;
    logic [15:0] pend_mask_o_awa;
    logic [15:0] stall_cnt_o_awa;
    logic        stall_clr_i_awa;

    modport slave (
        input  wen_vctr0_i_awa, wdata0_i_awa, wen_vctr1_i_awa, wdata1_i_awa, stall_clr_i_awa,
        output rdy0_o_awa, rdy1_o_awa, acc_wen_vctr_o_awa, acc_wdata_o_awa,
        output pend_mask_o_awa, stall_cnt_o_awa
    );

    modport master (
        output wen_vctr0_i_awa, wdata0_i_awa, wen_vctr1_i_awa, wdata1_i_awa, stall_clr_i_awa,
        input  rdy0_o_awa, rdy1_o_awa, acc_wen_vctr_o_awa, acc_wdata_o_awa,
        input  pend_mask_o_awa, stall_cnt_o_awa
    );
endinterface

// File: rtl/acc_wr_arb.sv
// Two-lane accumulator write arbiter: per-lane 2-entry FIFOs, round-robin grant,
// registered write port, pending-index mask and saturating stall counter.
module acc_wr_arb (
    input logic         clk_i_awa,
    input logic         rst_i_awa,
    acc_wr_arb_if.slave bus
);
    logic [4:0]  req_vctr [2];
    logic [31:0] req_data [2];
    logic [35:0] mem_q [2][2];
    logic        wr_ptr_q [2];
    logic        rd_ptr_q [2];
    logic [1:0]  cnt_q [2];
    logic [1:0]  cnt_d [2];
    logic [1:0]  req_vld, rdy, push, pop, head_vld;
    logic        rr_q, gnt_vld, gnt_lane, blocked;
    logic [35:0] head;
    logic [4:0]  out_vctr_q;
    logic [31:0] out_data_q;
    logic [15:0] stall_q, stall_d, pend;

    assign req_vctr[0] = bus.wen_vctr0_i_awa;
    assign req_vctr[1] = bus.wen_vctr1_i_awa;
    assign req_data[0] = bus.wdata0_i_awa;
    assign req_data[1] = bus.wdata1_i_awa;
    assign req_vld     = {req_vctr[1][4], req_vctr[0][4]};

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign rdy      = {cnt_q[1] != 2'd2, cnt_q[0] != 2'd2};
    assign head_vld = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
    assign push     = req_vld & rdy;
    assign blocked  = |(req_vld & ~rdy);

    always_comb begin
        gnt_vld  = |head_vld;
        gnt_lane = (&head_vld) ? rr_q : head_vld[1];
        pop      = {gnt_vld & gnt_lane, gnt_vld & ~gnt_lane};
        head     = mem_q[gnt_lane][rd_ptr_q[gnt_lane]];
        for (int l = 0; l < 2; l++) begin
            cnt_d[l] = cnt_q[l] + {1'b0, push[l]} - {1'b0, pop[l]};
        end
        if (bus.stall_clr_i_awa) begin
            stall_d = 16'h0;
        end else if (blocked && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    always_comb begin
        pend = 16'h0;
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 2; s++) begin
                if (cnt_q[l] == 2'd2 || (cnt_q[l] == 2'd1 && rd_ptr_q[l] == s[0])) begin
                    pend[mem_q[l][s][35:32]] = 1'b1;
                end
            end
        end
        if (out_vctr_q[4]) begin
            pend[out_vctr_q[3:0]] = 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk_i_awa) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                mem_q[l][wr_ptr_q[l]] <= {req_vctr[l][3:0], req_data[l]};
            end
        end
    end

    always_ff @(posedge clk_i_awa) begin
        if (rst_i_awa) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= 1'b0;
                rd_ptr_q[l] <= 1'b0;
                cnt_q[l]    <= 2'd0;
            end
            rr_q       <= 1'b0;
            out_vctr_q <= 5'h0;
            out_data_q <= 32'h0;
            stall_q    <= 16'h0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= wr_ptr_q[l] ^ push[l];
                rd_ptr_q[l] <= rd_ptr_q[l] ^ pop[l];
                cnt_q[l]    <= cnt_d[l];
            end
            if (gnt_vld) begin
                rr_q       <= ~gnt_lane;
                out_data_q <= head[31:0];
            end
            out_vctr_q <= gnt_vld ? {1'b1, head[35:32]} : 5'h0;
            stall_q    <= stall_d;
        end
    end

    assign bus.rdy0_o_awa         = rdy[0];
    assign bus.rdy1_o_awa         = rdy[1];
    assign bus.acc_wen_vctr_o_awa = out_vctr_q;
    assign bus.acc_wdata_o_awa    = out_data_q;
    assign bus.pend_mask_o_awa    = pend;
    assign bus.stall_cnt_o_awa    = stall_q;
endmodule

// File: tb/tb_acc_wr_arb.sv
// Directed self-checking bench for acc_wr_arb: one task per scenario, inline comparisons.
module tb_acc_wr_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    acc_wr_arb_if bus_if ();

    acc_wr_arb dut (
        .clk_i_awa (clk),
        .rst_i_awa (rst),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.wen_vctr0_i_awa = 5'h0;
        bus_if.wdata0_i_awa    = 32'h0;
        bus_if.wen_vctr1_i_awa = 5'h0;
        bus_if.wdata1_i_awa    = 32'h0;
        bus_if.stall_clr_i_awa = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h0) begin
            bad++;
            $display("FAIL reset_wen got=%h want=00", bus_if.acc_wen_vctr_o_awa);
        end
        total++;
        if (bus_if.acc_wdata_o_awa !== 32'h0) begin
            bad++;
            $display("FAIL reset_wdata got=%h want=00000000", bus_if.acc_wdata_o_awa);
        end
        total++;
        if (bus_if.pend_mask_o_awa !== 16'h0) begin
            bad++;
            $display("FAIL reset_pend got=%h want=0000", bus_if.pend_mask_o_awa);
        end
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'h0) begin
            bad++;
            $display("FAIL reset_stall got=%h want=0000", bus_if.stall_cnt_o_awa);
        end
        total++;
        if ({bus_if.rdy1_o_awa, bus_if.rdy0_o_awa} !== 2'b11) begin
            bad++;
            $display("FAIL reset_rdy got=%b%b want=11", bus_if.rdy1_o_awa, bus_if.rdy0_o_awa);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        bus_if.wen_vctr0_i_awa = 5'h13;
        bus_if.wdata0_i_awa    = 32'hDEADBEEF;
        tick();
        idle_inputs();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h0 || bus_if.pend_mask_o_awa !== 16'h0008) begin
            bad++;
            $display("FAIL single_n1 got wen=%h pend=%h want wen=00 pend=0008",
                     bus_if.acc_wen_vctr_o_awa, bus_if.pend_mask_o_awa);
        end
        tick();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h13 || bus_if.acc_wdata_o_awa !== 32'hDEADBEEF ||
            bus_if.pend_mask_o_awa !== 16'h0008) begin
            bad++;
            $display("FAIL single_n2 got wen=%h data=%h pend=%h want 13/deadbeef/0008",
                     bus_if.acc_wen_vctr_o_awa, bus_if.acc_wdata_o_awa, bus_if.pend_mask_o_awa);
        end
        tick();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h0 || bus_if.acc_wdata_o_awa !== 32'hDEADBEEF ||
            bus_if.pend_mask_o_awa !== 16'h0) begin
            bad++;
            $display("FAIL single_n3 got wen=%h data=%h pend=%h want 00/deadbeef/0000",
                     bus_if.acc_wen_vctr_o_awa, bus_if.acc_wdata_o_awa, bus_if.pend_mask_o_awa);
        end
    endtask

    task automatic test_pend_two_lanes();
        logic [4:0]  exp_wen  [4] = '{5'h00, 5'h15, 5'h19, 5'h00};
        logic [15:0] exp_pend [4] = '{16'h0220, 16'h0220, 16'h0200, 16'h0000};
        do_reset();
        bus_if.wen_vctr0_i_awa = 5'h15;
        bus_if.wdata0_i_awa    = 32'h1111_1111;
        bus_if.wen_vctr1_i_awa = 5'h19;
        bus_if.wdata1_i_awa    = 32'h2222_2222;
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            total++;
            if (bus_if.acc_wen_vctr_o_awa !== exp_wen[k] ||
                bus_if.pend_mask_o_awa !== exp_pend[k]) begin
                bad++;
                $display("FAIL pend_two_lanes[%0d] got wen=%h pend=%h want wen=%h pend=%h", k,
                         bus_if.acc_wen_vctr_o_awa, bus_if.pend_mask_o_awa,
                         exp_wen[k], exp_pend[k]);
            end
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp;
        do_reset();
        bus_if.wen_vctr0_i_awa = 5'h11;
        bus_if.wen_vctr1_i_awa = 5'h12;
        tick();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h0) begin
            bad++;
            $display("FAIL contention_first got=%h want=00", bus_if.acc_wen_vctr_o_awa);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = (k % 2 == 0) ? 5'h11 : 5'h12;
            total++;
            if (bus_if.acc_wen_vctr_o_awa !== exp) begin
                bad++;
                $display("FAIL contention[%0d] got=%h want=%h", k, bus_if.acc_wen_vctr_o_awa, exp);
            end
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_back_pressure();
        logic [35:0] exp0 [$];
        logic [35:0] exp1 [$];
        logic [35:0] got  [$];
        logic        r1   [10];
        logic        a0, a1;
        int          n0 = 0;
        int          n1 = 0;
        int          i0 = 0;
        int          i1 = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus_if.wen_vctr0_i_awa = 5'h1A;
            bus_if.wdata0_i_awa    = 32'hA000_0000 + n0;
            bus_if.wen_vctr1_i_awa = {1'b1, n1[3:0]};
            bus_if.wdata1_i_awa    = 32'hB000_0000 + n1;
            a0 = bus_if.rdy0_o_awa;
            a1 = bus_if.rdy1_o_awa;
            r1[c] = a1;
            tick();
            if (a0) begin
                exp0.push_back({4'hA, 32'hA000_0000 + n0});
                n0++;
            end
            if (a1) begin
                exp1.push_back({n1[3:0], 32'hB000_0000 + n1});
                n1++;
            end
            if (bus_if.acc_wen_vctr_o_awa[4]) begin
                got.push_back({bus_if.acc_wen_vctr_o_awa[3:0], bus_if.acc_wdata_o_awa});
            end
        end
        total++;
        if (r1[0] !== 1'b1 || r1[1] !== 1'b1 || r1[2] !== 1'b0) begin
            bad++;
            $display("FAIL bp_rdy1_drop got=%b%b%b want=110", r1[0], r1[1], r1[2]);
        end
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'd8) begin
            bad++;
            $display("FAIL bp_stall got=%0d want=8", bus_if.stall_cnt_o_awa);
        end
        idle_inputs();
        repeat (8) begin
            tick();
            if (bus_if.acc_wen_vctr_o_awa[4]) begin
                got.push_back({bus_if.acc_wen_vctr_o_awa[3:0], bus_if.acc_wdata_o_awa});
            end
        end
        total++;
        if (got.size() != n0 + n1) begin
            bad++;
            $display("FAIL bp_count got=%0d want=%0d", got.size(), n0 + n1);
        end
        for (int k = 0; k < got.size(); k++) begin
            if (k < 8) begin
                total++;
                if ((got[k][31:28] == 4'hB) != (k % 2 == 1)) begin
                    bad++;
                    $display("FAIL bp_alternate[%0d] got=%h", k, got[k]);
                end
            end
            if (got[k][31:28] == 4'hB) begin
                total++;
                if (i1 >= exp1.size() || got[k] !== exp1[i1]) begin
                    bad++;
                    $display("FAIL bp_lane1_order[%0d] got=%h", i1, got[k]);
                end
                i1++;
            end else begin
                total++;
                if (i0 >= exp0.size() || got[k] !== exp0[i0]) begin
                    bad++;
                    $display("FAIL bp_lane0_order[%0d] got=%h", i0, got[k]);
                end
                i0++;
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        bus_if.wen_vctr0_i_awa = 5'h14;
        bus_if.wen_vctr1_i_awa = 5'h17;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        total++;
        if (bus_if.acc_wen_vctr_o_awa !== 5'h0 || bus_if.pend_mask_o_awa !== 16'h0 ||
            bus_if.rdy0_o_awa !== 1'b1 || bus_if.rdy1_o_awa !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state got wen=%h pend=%h rdy=%b%b want 00/0000/11",
                     bus_if.acc_wen_vctr_o_awa, bus_if.pend_mask_o_awa,
                     bus_if.rdy1_o_awa, bus_if.rdy0_o_awa);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus_if.acc_wen_vctr_o_awa !== 5'h0 || bus_if.pend_mask_o_awa !== 16'h0) begin
                bad++;
                $display("FAIL midrst_quiet[%0d] got wen=%h pend=%h want 00/0000", k,
                         bus_if.acc_wen_vctr_o_awa, bus_if.pend_mask_o_awa);
            end
        end
    endtask

    task automatic test_stall_counter();
        do_reset();
        bus_if.wen_vctr0_i_awa = 5'h11;
        bus_if.wen_vctr1_i_awa = 5'h12;
        repeat (70000) tick();
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'hFFFF) begin
            bad++;
            $display("FAIL stall_saturate got=%h want=ffff", bus_if.stall_cnt_o_awa);
        end
        bus_if.stall_clr_i_awa = 1'b1;
        tick();
        bus_if.stall_clr_i_awa = 1'b0;
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'h0) begin
            bad++;
            $display("FAIL stall_clr_blocked got=%h want=0000", bus_if.stall_cnt_o_awa);
        end
        tick();
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'h1) begin
            bad++;
            $display("FAIL stall_inc got=%h want=0001", bus_if.stall_cnt_o_awa);
        end
        idle_inputs();
        tick();
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'h1) begin
            bad++;
            $display("FAIL stall_hold got=%h want=0001", bus_if.stall_cnt_o_awa);
        end
        bus_if.stall_clr_i_awa = 1'b1;
        tick();
        bus_if.stall_clr_i_awa = 1'b0;
        total++;
        if (bus_if.stall_cnt_o_awa !== 16'h0) begin
            bad++;
            $display("FAIL stall_clr_idle got=%h want=0000", bus_if.stall_cnt_o_awa);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_pend_two_lanes();
        test_contention();
        test_back_pressure();
        test_reset_mid_flight();
        test_stall_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
